// File: rtl/demux_load_ctrl.sv
// demux_load_ctrl: sequences one input frame into a 16-entry neuron input bank.
// Words from a valid/ready stream are written one per cycle through the bank's
// 1-to-16 enable demux. After N_WORDS writes the neuron array is kicked with a
// one-cycle layer_start. The block then waits for layer_done and pulses frame_done.
module demux_load_ctrl #(
  parameter int WIDTH   = 16,
  parameter int N_WORDS = 16   // 1..16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       wr_sel,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             layer_start,
  input  logic             layer_done,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic       accept;

  // Handshake and status are pure decodes of the state.
  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  // A word offered in the same cycle as abort is dropped.
  assign accept   = in_valid & in_ready & ~abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_LOAD;
        S_LOAD: if (accept && idx == LAST_IDX) state_nxt = S_FIRE;
        S_FIRE: state_nxt = S_WAIT;
        S_WAIT: if (layer_done) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Write index: cleared at frame start and abort, and after the last word.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      idx <= '0;
    end else if (state == S_IDLE && start) begin
      idx <= '0;
    end else if (accept) begin
      idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    end
  end

  // Registered bank-side and array-side outputs.
  // wr_sel and wr_data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_sel      <= '0;
      wr_data     <= '0;
      layer_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wr_en       <= accept;
      layer_start <= ~abort & (state == S_FIRE);
      frame_done  <= ~abort & (state == S_WAIT) & layer_done;
      if (accept) begin
        wr_sel  <= idx;
        wr_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux_load_ctrl.sv
// Testbench for demux_load_ctrl. Two instances are used: N_WORDS=16 and N_WORDS=1.
// A frame-level reference model predicts every write, layer_start and frame_done.
// Each prediction carries its expected cycle and goes into a per-instance queue.
// A negedge monitor pops and compares each pulse the DUTs produce.
module tb_demux_load_ctrl;

  localparam int W = 16;
  localparam int K_WR = 0, K_LS = 1, K_FD = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_FIRE = 2, M_WAIT = 3, M_DONE = 4;

  typedef struct {
    int kind;
    int sel;
    int data;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         st[2], ab[2], iv[2], ld_in[2];
  logic [W-1:0] din[2];
  logic         ir[2], we[2], ls[2], bz[2], fd[2];
  logic [3:0]   ws[2];
  logic [W-1:0] wd[2];

  int  cyc = 0;
  int  n_cmp = 0, n_err = 0;
  bit  mon_on = 1'b0;
  ev_t q[2][$];

  // Reference model: frame progress per instance.
  int mode[2] = '{M_IDLE, M_IDLE};
  int cnt[2]  = '{0, 0};
  int nw[2]   = '{16, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux_load_ctrl #(.WIDTH(W), .N_WORDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .in_valid(iv[0]),
    .in_data(din[0]), .in_ready(ir[0]), .wr_sel(ws[0]), .wr_en(we[0]),
    .wr_data(wd[0]), .layer_start(ls[0]), .layer_done(ld_in[0]),
    .busy(bz[0]), .frame_done(fd[0]));

  demux_load_ctrl #(.WIDTH(W), .N_WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .in_valid(iv[1]),
    .in_data(din[1]), .in_ready(ir[1]), .wr_sel(ws[1]), .wr_en(we[1]),
    .wr_data(wd[1]), .layer_start(ls[1]), .layer_done(ld_in[1]),
    .busy(bz[1]), .frame_done(fd[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, required %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic push(input int d, input int k, input int s, input int dat);
    ev_t e;
    e.kind = k; e.sel = s; e.data = dat; e.cyc = cyc + 1;
    q[d].push_back(e);
  endtask

  // Called with this cycle's inputs applied.
  // Checks the status outputs, then advances the model across the coming edge.
  task automatic present(input int d);
    chk("in_ready", d, 32'(ir[d]), 32'(mode[d] == M_LOAD));
    chk("busy", d, 32'(bz[d]), 32'(mode[d] != M_IDLE));
    if (rst || ab[d]) begin
      mode[d] = M_IDLE; cnt[d] = 0;
    end else begin
      case (mode[d])
        M_IDLE: if (st[d]) begin mode[d] = M_LOAD; cnt[d] = 0; end
        M_LOAD: if (iv[d]) begin
          push(d, K_WR, cnt[d], int'(din[d]));
          if (cnt[d] == nw[d] - 1) begin mode[d] = M_FIRE; cnt[d] = 0; end
          else cnt[d]++;
        end
        M_FIRE: begin push(d, K_LS, 0, 0); mode[d] = M_WAIT; end
        M_WAIT: if (ld_in[d]) begin push(d, K_FD, 0, 0); mode[d] = M_DONE; end
        default: mode[d] = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) present(d);
    @(posedge clk); #1;
  endtask

  // Match one observed pulse against the head of the expectation queue.
  task automatic see(input int d, input int k, input int s, input int dat);
    ev_t e;
    n_cmp++;
    if (q[d].size() == 0) begin
      n_err++;
      $display("FAIL event dut%0d cycle %0d: got kind=%0d sel=%0h data=%0h, required none", d, cyc, k, s, dat);
    end else begin
      e = q[d].pop_front();
      if (e.kind != k || e.cyc != cyc || (k == K_WR && (e.sel != s || e.data != dat))) begin
        n_err++;
        $display("FAIL event dut%0d cycle %0d: got kind=%0d sel=%0h data=%0h, required kind=%0d sel=%0h data=%0h at cycle %0d",
                 d, cyc, k, s, dat, e.kind, e.sel, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: flag predicted pulses that never appeared, then check those that did.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL missing dut%0d: got nothing, required kind=%0d sel=%0h data=%0h at cycle %0d",
                   d, q[d][0].kind, q[d][0].sel, q[d][0].data, q[d][0].cyc);
          void'(q[d].pop_front());
        end
        if (we[d] === 1'b1) see(d, K_WR, int'(ws[d]), int'(wd[d]));
        if (ls[d] === 1'b1) see(d, K_LS, 0, 0);
        if (fd[d] === 1'b1) see(d, K_FD, 0, 0);
      end
    end
  end

  // One complete frame.
  // base<0 gives random data; otherwise word k carries base+k.
  // vprob==0 gives the 1,0,0 valid pattern; otherwise it is the percent chance of valid.
  // dly is the number of WAIT cycles before done, counting the layer_start cycle.
  // noise adds ignored start/layer_done pulses.
  task automatic frame(input int d, input int base, input int vprob, input int dly, input bit noise);
    int p = 0;
    int guard = 0;
    st[d] = 1'b1; tick(); st[d] = 1'b0;
    while (mode[d] == M_LOAD && guard < 1000) begin
      iv[d]  = (vprob == 0) ? (p % 3 == 0) : ($urandom_range(99) < vprob);
      din[d] = (base < 0) ? W'($urandom) : W'(base + cnt[d]);
      if (noise) begin
        st[d]    = ($urandom_range(3) == 0);
        ld_in[d] = ($urandom_range(3) == 0);
      end
      p++; guard++;
      tick();
    end
    chk("load_bound", d, 32'(guard < 1000), 32'd1);
    iv[d] = 1'b0; st[d] = 1'b0; ld_in[d] = noise;
    tick();                               // FIRE cycle
    ld_in[d] = 1'b0; st[d] = noise;
    repeat (dly) tick();                  // layer_start cycle onward
    st[d] = 1'b0; ld_in[d] = 1'b1;
    tick();
    ld_in[d] = 1'b0;
    tick();                               // DONE cycle
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; ab[d] = 0; iv[d] = 1; ld_in[d] = 0; din[d] = '0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    tick();                               // second reset cycle
    rst = 1'b0;
    repeat (3) tick();                    // valid held high, no start: nothing happens
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr_sel", d, 32'(ws[d]), 32'd0);
      chk("rst_wr_data", d, 32'(wd[d]), 32'd0);
      chk("rst_wr_en", d, 32'(we[d]), 32'd0);
      chk("rst_layer_start", d, 32'(ls[d]), 32'd0);
      chk("rst_frame_done", d, 32'(fd[d]), 32'd0);
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    tick();

    frame(0, 'h0100, 100, 3, 1'b0);       // full back-to-back frame
    tick();
    frame(0, -1, 0, 2, 1'b1);             // stalled input with ignored events
    tick();

    // Abort at idx 7 with a word offered: dropped, then a clean restart.
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (7) begin iv[0] = 1'b1; din[0] = W'($urandom); tick(); end
    ab[0] = 1'b1; din[0] = 16'hDEAD; tick();
    ab[0] = 1'b0; iv[0] = 1'b0;
    tick();
    frame(0, -1, 100, 1, 1'b0);

    // Reset in the middle of a load.
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (5) begin iv[0] = 1'b1; din[0] = W'($urandom); tick(); end
    rst = 1'b1; tick(); rst = 1'b0; iv[0] = 1'b0;
    tick();

    frame(1, 'hABCD, 100, 2, 1'b0);       // single-word frame
    tick();
    frame(1, -1, 50, 1, 1'b1);

    for (int i = 0; i < 4; i++)
      frame(0, -1, int'($urandom_range(30, 100)), int'($urandom_range(1, 5)), 1'b1);

    repeat (5) tick();
    for (int d = 0; d < 2; d++) chk("queue_empty", d, 32'(q[d].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
